// File: rtl/canvas_pkg.sv
// Shared constants and types for the canvas frame-buffer arbiter.
// Read tags travel alongside BRAM reads so returning data finds its owner.
package canvas_pkg;

    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 8;
    localparam int CANVAS_W     = 320;
    localparam int CANVAS_H     = 240;
    localparam int DEPTH        = CANVAS_W * CANVAS_H;
    localparam int READ_LATENCY = 2;
    localparam logic [DATA_W-1:0] BG_PIXEL = 8'h00;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_DRAW = 2'd2
    } owner_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // oor marks a read that never touched the BRAM and must return BG_PIXEL
    typedef struct packed {
        owner_t owner;
        logic   oor;
    } rd_tag_t;

endpackage

// File: rtl/canvas_bram_arbiter_if.sv
// Bundles the VGA, draw, clear and BRAM-side signals of the canvas arbiter.
// slave = arbiter side, master = the users and the BRAM primitive.
interface canvas_bram_arbiter_if #(
    parameter int ADDR_W = canvas_pkg::ADDR_W,
    parameter int DATA_W = canvas_pkg::DATA_W
);
    logic              vga_req_in;
    logic [ADDR_W-1:0] vga_addr_in;
    logic [DATA_W-1:0] vga_data_out;
    logic              vga_valid_out;

    logic              draw_req_in;
    logic              draw_we_in;
    logic [ADDR_W-1:0] draw_addr_in;
    logic [DATA_W-1:0] draw_wdata_in;
    logic              draw_ready_out;
    logic [DATA_W-1:0] draw_rdata_out;
    logic              draw_rvalid_out;

    logic              clear_start_in;
    logic              clear_busy_out;
    logic              clear_done_out;

    logic [ADDR_W-1:0] bram_addr_out;
    logic              bram_we_out;
    logic [DATA_W-1:0] bram_din_out;
    logic [DATA_W-1:0] bram_dout_in;

    modport slave (
        input  vga_req_in, vga_addr_in,
        input  draw_req_in, draw_we_in, draw_addr_in, draw_wdata_in,
        input  clear_start_in, bram_dout_in,
        output vga_data_out, vga_valid_out,
        output draw_ready_out, draw_rdata_out, draw_rvalid_out,
        output clear_busy_out, clear_done_out,
        output bram_addr_out, bram_we_out, bram_din_out
    );

    modport master (
        output vga_req_in, vga_addr_in,
        output draw_req_in, draw_we_in, draw_addr_in, draw_wdata_in,
        output clear_start_in, bram_dout_in,
        input  vga_data_out, vga_valid_out,
        input  draw_ready_out, draw_rdata_out, draw_rvalid_out,
        input  clear_busy_out, clear_done_out,
        input  bram_addr_out, bram_we_out, bram_din_out
    );

endinterface

// File: rtl/read_tag_pipe.sv
// Shift register of read tags aligned with the BRAM read latency; steers the
// returning pixel (or BG_PIXEL for out-of-range reads) to its requester.
module read_tag_pipe #(
    parameter int STAGES = 3,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] BG_PIXEL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  canvas_pkg::rd_tag_t tag_i,
    input  logic [DATA_W-1:0]  bram_dout_i,
    output logic [DATA_W-1:0]  vga_data_o,
    output logic               vga_valid_o,
    output logic [DATA_W-1:0]  draw_rdata_o,
    output logic               draw_rvalid_o
);
    import canvas_pkg::*;

    localparam int TAG_W = $bits(rd_tag_t);

    logic [STAGES-1:0][TAG_W-1:0] tag_q;
    rd_tag_t                      head;
    logic [DATA_W-1:0]            pix;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[STAGES-2:0], tag_i};
        end
    end

    assign head = rd_tag_t'(tag_q[STAGES-1]);
    assign pix  = head.oor ? BG_PIXEL : bram_dout_i;

    // data buses stay at zero outside their valid pulse
    assign vga_valid_o   = (head.owner == OWN_VGA);
    assign draw_rvalid_o = (head.owner == OWN_DRAW);
    assign vga_data_o    = vga_valid_o   ? pix : '0;
    assign draw_rdata_o  = draw_rvalid_o ? pix : '0;

endmodule

// File: rtl/canvas_bram_arbiter.sv
// Single owner of the canvas BRAM port: schedules VGA reads, the clear engine
// and draw accesses (priority in that order) onto registered BRAM signals.
module canvas_bram_arbiter #(
    parameter int ADDR_W       = canvas_pkg::ADDR_W,
    parameter int DATA_W       = canvas_pkg::DATA_W,
    parameter int DEPTH        = canvas_pkg::DEPTH,
    parameter int READ_LATENCY = canvas_pkg::READ_LATENCY,
    parameter logic [DATA_W-1:0] BG_PIXEL = canvas_pkg::BG_PIXEL
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    canvas_bram_arbiter_if.slave  bus
);
    import canvas_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              done_q, done_d;
    rd_tag_t           tag_d;
    logic              grant_draw;
    logic              vga_oor, draw_oor;

    assign vga_oor  = (bus.vga_addr_in  >= DEPTH_A);
    assign draw_oor = (bus.draw_addr_in >= DEPTH_A);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        din_d      = din_q;
        done_d     = 1'b0;
        tag_d      = '{owner: OWN_NONE, oor: 1'b0};
        grant_draw = 1'b0;

        if (bus.vga_req_in) begin
            tag_d = '{owner: OWN_VGA, oor: vga_oor};
            if (!vga_oor) begin
                addr_d = bus.vga_addr_in;
            end
        end else if (state_q == CLEAR) begin
            addr_d = cnt_q;
            we_d   = 1'b1;
            din_d  = BG_PIXEL;
            // done is registered so it lines up with the last write on the port
            if (cnt_q == LAST_A) begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.draw_req_in) begin
            grant_draw = 1'b1;
            if (!draw_oor) begin
                addr_d = bus.draw_addr_in;
                we_d   = bus.draw_we_in;
                if (bus.draw_we_in) begin
                    din_d = bus.draw_wdata_in;
                end
            end
            if (!bus.draw_we_in) begin
                tag_d = '{owner: OWN_DRAW, oor: draw_oor};
            end
        end

        // a draw granted alongside the start still completes as an IDLE access
        if (state_q == IDLE && bus.clear_start_in) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    assign bus.draw_ready_out = grant_draw & ~rst_in;
    assign bus.clear_busy_out = (state_q == CLEAR);
    assign bus.clear_done_out = done_q;
    assign bus.bram_addr_out  = addr_q;
    assign bus.bram_we_out    = we_q;
    assign bus.bram_din_out   = din_q;

    read_tag_pipe #(
        .STAGES   (READ_LATENCY + 1),
        .DATA_W   (DATA_W),
        .BG_PIXEL (BG_PIXEL)
    ) u_read_tag_pipe (
        .clk_i         (clk_in),
        .rst_i         (rst_in),
        .tag_i         (tag_d),
        .bram_dout_i   (bus.bram_dout_in),
        .vga_data_o    (bus.vga_data_out),
        .vga_valid_o   (bus.vga_valid_out),
        .draw_rdata_o  (bus.draw_rdata_out),
        .draw_rvalid_o (bus.draw_rvalid_out)
    );

endmodule

// File: tb/tb_canvas_bram_arbiter.sv
// Directed bench for canvas_bram_arbiter on a reduced 4800-location canvas
// with a two-cycle-latency BRAM model.
module tb_canvas_bram_arbiter;

    localparam int TB_DEPTH = 4800;
    localparam int AW       = 17;
    localparam int DW       = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    canvas_bram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    canvas_bram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DEPTH        (TB_DEPTH),
        .READ_LATENCY (2),
        .BG_PIXEL     (8'h00)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    logic [7:0] mem [TB_DEPTH];
    logic [7:0] rd1, rd2;

    always @(posedge clk) begin
        if (bus.bram_we_out && int'(bus.bram_addr_out) < TB_DEPTH)
            mem[bus.bram_addr_out[12:0]] <= bus.bram_din_out;
        rd1 <= (int'(bus.bram_addr_out) < TB_DEPTH) ? mem[bus.bram_addr_out[12:0]] : 8'hEE;
        rd2 <= rd1;
    end
    assign bus.bram_dout_in = rd2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] outs();
        return {bus.bram_addr_out, bus.bram_we_out, bus.bram_din_out,
                bus.vga_valid_out, bus.vga_data_out,
                bus.draw_ready_out, bus.draw_rvalid_out, bus.draw_rdata_out,
                bus.clear_busy_out, bus.clear_done_out};
    endfunction

    task automatic draw_wr(input int a, input logic [7:0] d);
        bus.draw_req_in   = 1'b1;
        bus.draw_we_in    = 1'b1;
        bus.draw_addr_in  = AW'(a);
        bus.draw_wdata_in = d;
        @(negedge clk);
        bus.draw_req_in = 1'b0;
        bus.draw_we_in  = 1'b0;
    endtask

    task automatic draw_rd(input int a, output logic [7:0] d, output int lat);
        bus.draw_req_in  = 1'b1;
        bus.draw_we_in   = 1'b0;
        bus.draw_addr_in = AW'(a);
        @(negedge clk);
        bus.draw_req_in = 1'b0;
        lat = 1;
        while (!bus.draw_rvalid_out && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        d = bus.draw_rdata_out;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vexp [3];
        logic [7:0] rdat;
        int lat, busy_cnt, done_cnt, ready_hi, rv_cnt, nz, guard;
        logic drop, done_ok;

        vexp[0] = 8'h3F; vexp[1] = 8'h20; vexp[2] = 8'h15;
        bus.vga_req_in = 0; bus.vga_addr_in = '0;
        bus.draw_req_in = 0; bus.draw_we_in = 0; bus.draw_addr_in = '0; bus.draw_wdata_in = '0;
        bus.clear_start_in = 0;

        // reset: everything zero, ready masked even with a pending draw
        #1 rst = 1'b1;
        #1 bus.draw_req_in = 1'b1;
        #1 chk("reset_outs", 64'(outs()), 64'd0);
        bus.draw_req_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // preload through the draw port
        draw_wr(0, 8'h3F);
        draw_wr(1, 8'h20);
        draw_wr(2, 8'h15);
        @(negedge clk);
        chk("idle_we_low", 64'(bus.bram_we_out), 64'd0);
        chk("idle_addr_hold", 64'(bus.bram_addr_out), 64'd2);

        // VGA reads on consecutive cycles, data three cycles later
        for (int k = 0; k < 6; k++) begin
            if (k >= 3) begin
                chk($sformatf("vga_valid_%0d", k), 64'(bus.vga_valid_out), 64'd1);
                chk($sformatf("vga_data_%0d", k), 64'(bus.vga_data_out), 64'(vexp[k-3]));
            end else begin
                chk($sformatf("vga_quiet_%0d", k), 64'(bus.vga_valid_out), 64'd0);
            end
            bus.vga_req_in  = (k < 3);
            bus.vga_addr_in = AW'(k);
            @(negedge clk);
        end

        // contention: draw write to 4150 blocked by 4 VGA cycles
        bus.draw_req_in = 1; bus.draw_we_in = 1; bus.draw_addr_in = AW'(4150); bus.draw_wdata_in = 8'h45;
        bus.vga_req_in = 1; bus.vga_addr_in = '0;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("contend_ready_low_%0d", k), 64'(bus.draw_ready_out), 64'd0);
            @(negedge clk);
        end
        bus.vga_req_in = 0;
        #1 chk("contend_ready_high", 64'(bus.draw_ready_out), 64'd1);
        @(negedge clk);
        bus.draw_req_in = 0; bus.draw_we_in = 0;
        chk("contend_we", 64'(bus.bram_we_out), 64'd1);
        chk("contend_addr", 64'(bus.bram_addr_out), 64'd4150);
        chk("contend_din", 64'(bus.bram_din_out), 64'h45);
        @(negedge clk);
        chk("contend_we_drop", 64'(bus.bram_we_out), 64'd0);
        draw_rd(4150, rdat, lat);
        chk("raw_rdata", 64'(rdat), 64'h45);
        chk("raw_latency", 64'(lat), 64'd3);

        // out-of-range VGA read: no access, BG_PIXEL at latency 3
        bus.vga_req_in = 1; bus.vga_addr_in = AW'(76800);
        @(negedge clk);
        bus.vga_req_in = 0;
        chk("oor_vga_we", 64'(bus.bram_we_out), 64'd0);
        chk("oor_vga_addr_hold", 64'(bus.bram_addr_out), 64'd4150);
        chk("oor_vga_early", 64'(bus.vga_valid_out), 64'd0);
        repeat (2) @(negedge clk);
        chk("oor_vga_valid", 64'(bus.vga_valid_out), 64'd1);
        chk("oor_vga_data", 64'(bus.vga_data_out), 64'h00);

        // out-of-range draw write: handshake, dropped
        bus.draw_req_in = 1; bus.draw_we_in = 1; bus.draw_addr_in = AW'(80000); bus.draw_wdata_in = 8'hAA;
        #1 chk("oor_draw_ready", 64'(bus.draw_ready_out), 64'd1);
        @(negedge clk);
        bus.draw_req_in = 0; bus.draw_we_in = 0;
        chk("oor_draw_we", 64'(bus.bram_we_out), 64'd0);
        chk("oor_draw_addr_hold", 64'(bus.bram_addr_out), 64'd4150);
        draw_rd(5000, rdat, lat);
        chk("oor_draw_rdata", 64'(rdat), 64'h00);
        chk("oor_draw_latency", 64'(lat), 64'd3);

        // draw write and clear start in the same idle cycle
        bus.draw_req_in = 1; bus.draw_we_in = 1; bus.draw_addr_in = AW'(7); bus.draw_wdata_in = 8'h5A;
        bus.clear_start_in = 1;
        #1 chk("sim_ready", 64'(bus.draw_ready_out), 64'd1);
        chk("sim_busy_before", 64'(bus.clear_busy_out), 64'd0);
        @(negedge clk);
        bus.clear_start_in = 0;
        bus.draw_we_in = 0; bus.draw_addr_in = AW'(2);
        #1;
        chk("sim_busy_rise", 64'(bus.clear_busy_out), 64'd1);
        chk("sim_first_we", 64'(bus.bram_we_out), 64'd1);
        chk("sim_first_addr", 64'(bus.bram_addr_out), 64'd7);
        chk("sim_first_din", 64'(bus.bram_din_out), 64'h5A);
        chk("clear_ready_low", 64'(bus.draw_ready_out), 64'd0);
        busy_cnt = 1; done_cnt = 0; ready_hi = 0; rv_cnt = 0; drop = 0; done_ok = 0; rdat = 8'hFF;
        for (int i = 0; i < TB_DEPTH + 12; i++) begin
            @(negedge clk);
            if (bus.clear_busy_out) busy_cnt++;
            if (bus.clear_busy_out && bus.draw_ready_out) ready_hi++;
            if (bus.clear_done_out) begin
                done_cnt++;
                done_ok = bus.bram_we_out && (int'(bus.bram_addr_out) == TB_DEPTH - 1);
            end
            if (bus.draw_rvalid_out) begin
                rv_cnt++;
                rdat = bus.draw_rdata_out;
            end
            if (drop) begin
                bus.draw_req_in = 0;
                drop = 0;
            end else if (bus.draw_req_in && bus.draw_ready_out) begin
                drop = 1;
            end
        end
        chk("clear_busy_cycles", 64'(busy_cnt), 64'(TB_DEPTH));
        chk("clear_done_count", 64'(done_cnt), 64'd1);
        chk("clear_done_with_last_write", 64'(done_ok), 64'd1);
        chk("clear_ready_never", 64'(ready_hi), 64'd0);
        chk("post_clear_rvalid_count", 64'(rv_cnt), 64'd1);
        chk("post_clear_rdata", 64'(rdat), 64'h00);
        nz = 0;
        for (int i = 0; i < TB_DEPTH; i++) if (mem[i] !== 8'h00) nz++;
        chk("clear_all_bg", 64'(nz), 64'd0);

        // clear with VGA on every other cycle
        bus.clear_start_in = 1;
        @(negedge clk);
        bus.clear_start_in = 0;
        busy_cnt = bus.clear_busy_out ? 1 : 0;
        done_cnt = 0;
        bus.vga_req_in = 1; bus.vga_addr_in = AW'(1);
        for (int i = 0; i < 2 * TB_DEPTH + 10; i++) begin
            @(negedge clk);
            if (bus.clear_busy_out) busy_cnt++;
            if (bus.clear_done_out) done_cnt++;
            bus.vga_req_in = bus.clear_busy_out ? !bus.vga_req_in : 1'b0;
        end
        chk("vga_clear_busy_cycles", 64'(busy_cnt), 64'(2 * TB_DEPTH));
        chk("vga_clear_done_count", 64'(done_cnt), 64'd1);

        // reset while the clear counter sits at 1000
        draw_wr(998, 8'h66);
        draw_wr(1000, 8'h77);
        draw_wr(TB_DEPTH - 1, 8'h88);
        @(negedge clk);
        bus.clear_start_in = 1;
        @(negedge clk);
        bus.clear_start_in = 0;
        busy_cnt = bus.clear_busy_out ? 1 : 0;
        done_cnt = 0; guard = 0;
        while (busy_cnt < 1000 && guard < 2000) begin
            @(negedge clk);
            if (bus.clear_busy_out) busy_cnt++;
            if (bus.clear_done_out) done_cnt++;
            guard++;
        end
        chk("midclear_reach_1000", 64'(busy_cnt), 64'd1000);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("midclear_reset_outs", 64'(outs()), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (bus.clear_done_out) done_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (bus.clear_done_out) done_cnt++;
        chk("midclear_no_done", 64'(done_cnt), 64'd0);
        chk("midclear_busy_low", 64'(bus.clear_busy_out), 64'd0);
        chk("midclear_mem998", 64'(mem[998]), 64'h00);
        chk("midclear_mem1000", 64'(mem[1000]), 64'h77);
        chk("midclear_memlast", 64'(mem[TB_DEPTH-1]), 64'h88);
        bus.draw_req_in = 1; bus.draw_we_in = 0; bus.draw_addr_in = AW'(3);
        #1 chk("midclear_idle_ready", 64'(bus.draw_ready_out), 64'd1);
        @(negedge clk);
        bus.draw_req_in = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canvas_bram_arbiter.md
Name: canvas_bram_arbiter

Overview:
- Sole owner of the single-port canvas frame BRAM (320x240, 8-bit pixels).
- Shares the BRAM between three users: VGA readout, the draw/compare read-modify-write path, and an internal full-canvas clear engine.
- Sits between the compare/draw logic, the VGA pixel pipeline and the BRAM primitive. It schedules every BRAM access and routes read data back to the requester that issued it.

Parameters:
- ADDR_W, 17, BRAM address width
- DATA_W, 8, pixel width
- DEPTH, 76800, valid canvas locations (320*240); addresses >= DEPTH are out of range
- READ_LATENCY, 2, BRAM dout delay in cycles after the address is presented
- BG_PIXEL, 8'h00, value written by clear and returned for out-of-range reads

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- vga_req_in  in  1  VGA read request, one per cycle, never stalled
- vga_addr_in  in  ADDR_W  VGA read address
- vga_data_out  out  DATA_W  VGA read data
- vga_valid_out  out  1  vga_data_out valid, one-cycle pulse
- draw_req_in  in  1  draw access request, held until granted
- draw_we_in  in  1  1 = write, 0 = read
- draw_addr_in  in  ADDR_W  draw address
- draw_wdata_in  in  DATA_W  draw write data
- draw_ready_out  out  1  grant; transfer occurs on the edge where req && ready
- draw_rdata_out  out  DATA_W  draw read data
- draw_rvalid_out  out  1  draw_rdata_out valid, one-cycle pulse
- clear_start_in  in  1  pulse to begin a canvas clear
- clear_busy_out  out  1  clear in progress
- clear_done_out  out  1  one-cycle pulse when the clear completes
- bram_addr_out  out  ADDR_W  BRAM address (registered)
- bram_we_out  out  1  BRAM write enable (registered)
- bram_din_out  out  DATA_W  BRAM write data (registered)
- bram_dout_in  in  DATA_W  BRAM read data

Behaviour:
- Reset: every output is 0; state = IDLE; clear counter = 0; tag pipe flushed. A reset mid-clear aborts with no done pulse, and in-flight reads are discarded (no valid pulses).
- Priority each cycle: VGA > clear > draw.
  - VGA is always serviced in the cycle it is requested.
  - draw_ready_out = draw_req_in && !vga_req_in && state==IDLE (combinational).
- BRAM port signals are registered: the access issues on the cycle after grant. Read data returns READ_LATENCY+1 = 3 cycles after the grant edge, matched to its owner by a tag pipe of depth READ_LATENCY+1.
- Idle cycles drive bram_we_out = 0; bram_addr_out holds its last value.
- Out-of-range address (>= DEPTH):
  - the BRAM is not accessed (we = 0);
  - a read still returns BG_PIXEL with the normal valid pulse at the normal latency;
  - a draw write is dropped but still handshakes (ready asserted).
- FSM IDLE -> CLEAR:
  - Entered on clear_start_in in IDLE; counter = 0. If a draw is granted in the same cycle, it completes first (state is still IDLE), and clearing starts the next cycle.
  - In CLEAR, each cycle without vga_req_in writes BG_PIXEL at the counter address and increments the counter. VGA-occupied cycles stall the counter.
  - After writing DEPTH-1: clear_done_out pulses in the same cycle as the final write issue, busy drops, and the FSM returns to IDLE.
  - clear_start_in during CLEAR is ignored (no restart).
  - draw_ready_out = 0 throughout CLEAR.
- Read-after-write ordering is preserved: accesses issue in grant order, so a draw read granted after a draw write to the same address returns the new value.
- Back-to-back grants are allowed every cycle; there is no turnaround bubble.

Decomposition:
- canvas_pkg holds:
  - constants: ADDR_W, DATA_W, CANVAS_W = 320, CANVAS_H = 240, DEPTH, BG_PIXEL
  - owner_t enum {OWN_NONE, OWN_VGA, OWN_DRAW}
  - arb_state_t enum {IDLE, CLEAR}
- Sub-module read_tag_pipe: parameterised shift register of {owner_t, oor flag}. It demuxes bram_dout_in or BG_PIXEL to vga_*/draw_* outputs.

Test Plan:
- VGA only: vga_req_in=1 with addr 0,1,2 on consecutive cycles (BRAM preloaded 8'h3F, 8'h20, 8'h15) -> vga_valid_out high 3 cycles after each request with data 3F, 20, 15 in order.
- Contention: draw write addr 100*320+150 = 32150, data 8'h45, held while vga_req_in=1 for 4 cycles -> draw_ready_out low for those 4 cycles; the write issues on cycle 5; a later draw read of 32150 returns 8'h45 with draw_rvalid_out.
- Clear: clear_start_in pulse with no VGA traffic -> clear_busy_out high for exactly 76800 cycles; clear_done_out pulses once; every location reads BG_PIXEL afterwards. Repeat with VGA requesting every other cycle -> busy for 153600 cycles.
- Reset mid-clear: assert rst_in at counter = 1000 -> all outputs 0 immediately, no done pulse. Locations >= 1000 keep their old contents.
- Out of range: VGA read of addr 76800 and draw write to 80000 -> VGA returns 8'h00 with valid at latency 3; the draw handshakes and bram_we_out stays 0.
- Simultaneous: draw_req_in and clear_start_in in the same idle cycle -> draw granted that cycle; busy rises next cycle; the draw is the first BRAM write issued.
